// File: rtl/link_buffer_pkg.sv
// Shared flit geometry and helpers for the receive-side link buffer.
package link_buffer_pkg;

  localparam int HDR_SZ  = 4;
  localparam int PL_SZ   = 8;
  localparam int ADDR_SZ = 4;
  localparam int FLIT_W  = HDR_SZ + PL_SZ + ADDR_SZ + 1;

  // Bit positions inside a flit: parity at MSB, dest in the LSBs.
  localparam int PAR_BIT = FLIT_W - 1;
  localparam int HDR_LSB = PL_SZ + ADDR_SZ;
  localparam int PL_LSB  = ADDR_SZ;

  typedef struct packed {
    logic               par;
    logic [HDR_SZ-1:0]  hdr;
    logic [PL_SZ-1:0]   pl;
    logic [ADDR_SZ-1:0] dest;
  } flit_t;

  // Even parity over the whole flit, parity bit included.
  function automatic logic flit_parity_ok(input logic [FLIT_W-1:0] f);
    return ~(^f);
  endfunction

endpackage

// File: rtl/link_buffer_fifo.sv
// Small synchronous FIFO; memory, pointers and occupancy count.
// The caller guarantees push only when not full or popping, pop only when not empty.
module flit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;

  // Storage and pointer update; memory cleared so the head reads 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/link_buffer.sv
// Receive link buffer: parity check, FIFO, flow control and debug counters.
module link_buffer
  import link_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SKID  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] in_item,
  input  logic              in_req,
  output logic              channel_busy,
  output logic [FLIT_W-1:0] out_item,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              parity_err,
  output logic              overflow,
  output logic [7:0]        err_cnt,
  output logic [15:0]       flit_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] BUSY_TH = CW'(DEPTH - SKID);

  logic          good, bad, push, pop, full, empty;
  logic [CW-1:0] count;

  assign good = in_req & flit_parity_ok(in_item);
  assign bad  = in_req & ~flit_parity_ok(in_item);
  assign pop  = out_valid & out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push = good & (~full | pop);

  flit_fifo #(.DEPTH(DEPTH), .WIDTH(FLIT_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (in_item),
    .rdata (out_item),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign out_valid    = ~empty;
  assign channel_busy = (count >= BUSY_TH);

  // Error pulse, sticky overflow and debug counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err <= 1'b0;
      overflow   <= 1'b0;
      err_cnt    <= '0;
      flit_cnt   <= '0;
    end else begin
      parity_err <= bad;
      if (good & ~push) overflow <= 1'b1;
      if (bad && err_cnt != 8'hff) err_cnt <= err_cnt + 1'b1;
      if (push) flit_cnt <= flit_cnt + 1'b1;
    end
  end

endmodule
